// File: rtl/sr_pkg.sv
// Shared types and sizes for the multicycle right-shift unit.
package sr_pkg;
  localparam int WORD_W  = 16;
  localparam int SHAMT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/sr_step.sv
// Combinational one-bit right step: shifts in the fill bit at the MSB and exposes the bit that falls off.
module sr_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_fill,
  output logic [WIDTH-1:0] o_d,
  output logic             o_bit
);
  assign o_d   = {i_fill, i_d[WIDTH-1:1]};
  assign o_bit = i_d[0];
endmodule

// File: rtl/sr_seq.sv
// Multicycle right shifter, one bit per clock, start/done handshake.
// Define SR_ARITH_EN to enable sign fill through the arith input.
module sr_seq
  import sr_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int SHW   = SHAMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   amt,
  input  logic             arith,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             sticky
);
  state_t           r_state;
  logic [WIDTH-1:0] r_y;
  logic [SHW-1:0]   r_cnt;
  logic             r_cout, r_sticky;
  logic [WIDTH-1:0] w_y_nxt;
  logic             w_fill, w_out, w_accept;

  assign w_accept = (r_state == IDLE) && start;

`ifdef SR_ARITH_EN
  logic r_fill;
  assign w_fill = r_fill;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)        r_fill <= 1'b0;
    else if (w_accept) r_fill <= arith & a[WIDTH-1];
`else
  logic w_unused_arith;
  assign w_unused_arith = arith;
  assign w_fill         = 1'b0;
`endif

  sr_step #(.WIDTH(WIDTH)) u_step (
    .i_d   (r_y),
    .i_fill(w_fill),
    .o_d   (w_y_nxt),
    .o_bit (w_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_y      <= '0;
      r_cnt    <= '0;
      r_cout   <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_y      <= a;
          r_cnt    <= amt;
          r_cout   <= 1'b0;
          r_sticky <= 1'b0;
          r_state  <= (amt != '0) ? SHIFT : DONE;
        end
        SHIFT: begin
          r_y      <= w_y_nxt;
          r_cout   <= w_out;
          r_sticky <= r_sticky | w_out;
          r_cnt    <= r_cnt - 1'b1;
          // last step lands count on zero, so it never wraps
          if (r_cnt == SHW'(1)) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready  = (r_state == IDLE);
  assign busy   = (r_state == SHIFT);
  assign done   = (r_state == DONE);
  assign y      = r_y;
  assign cout   = r_cout;
  assign sticky = r_sticky;
endmodule

// File: tb/tb_sr_seq.sv
// Directed scoreboard bench for sr_seq: expected results queued at issue, checked at done.
module tb_sr_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [3:0]  amt = '0;
  logic        arith = 1'b0;
  logic        ready, busy, done, cout, sticky;
  logic [15:0] y;

  typedef struct packed {
    logic [15:0] y;
    logic        cout;
    logic        sticky;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  sr_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .amt(amt), .arith(arith),
    .ready(ready), .busy(busy), .done(done), .y(y), .cout(cout), .sticky(sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ma, input logic [3:0] mamt, input logic mar);
    exp_t        e;
    logic        fill;
    logic [15:0] mask;
    fill = 1'b0;
`ifdef SR_ARITH_EN
    fill = mar & ma[15];
`else
    if (mar) fill = 1'b0;
`endif
    e.y      = fill ? 16'($signed(ma) >>> mamt) : (ma >> mamt);
    mask     = (16'h1 << mamt) - 16'h1;
    e.cout   = (mamt == 4'd0) ? 1'b0 : ma[mamt - 4'd1];
    e.sticky = |(ma & mask);
    return e;
  endfunction

  task automatic compare_result(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_y"}, 32'(y), 32'(e.y));
      chk({tag, "_cout"}, 32'(cout), 32'(e.cout));
      chk({tag, "_sticky"}, 32'(sticky), 32'(e.sticky));
    end
  endtask

  // Issue one op from IDLE, scramble inputs after accept, check latency, busy time and result.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [3:0] tamt, input logic tar);
    int lat, bcnt;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    start = 1'b1; a = ta; amt = tamt; arith = tar;
    sb.push_back(model(ta, tamt, tar));
    @(negedge clk);
    start = 1'b0; a = ~ta; amt = ~tamt; arith = ~tar;
    lat = 1; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(tamt) + 32'd1);
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(tamt));
    compare_result(tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_y_held"}, 32'(y), 32'(model(ta, tamt, tar).y));
  endtask

  initial begin
    int lat, seen_done;
    exp_t e1800;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_sticky", 32'(sticky), 32'd0);
    rst_n = 1'b1;

    run_op("ffff_4", 16'hFFFF, 4'd4, 1'b0);
    run_op("abcd_0", 16'hABCD, 4'd0, 1'b0);
    run_op("abcd_8", 16'hABCD, 4'd8, 1'b0);
    run_op("0100_8", 16'h0100, 4'd8, 1'b0);
    run_op("8000_15a", 16'h8000, 4'd15, 1'b1);
    run_op("8000_15l", 16'h8000, 4'd15, 1'b0);
    run_op("c001_1a", 16'hC001, 4'd1, 1'b1);

    // start pulses during SHIFT and DONE must be ignored
    @(negedge clk);
    start = 1'b1; a = 16'h1234; amt = 4'd3; arith = 1'b0;
    sb.push_back(model(16'h1234, 4'd3, 1'b0));
    @(negedge clk);
    start = 1'b0; a = 16'hFFFF; amt = 4'd1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b1;
    lat = 3;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    chk("ign_latency", 32'(lat), 32'd4);
    compare_result("ign");
    @(negedge clk);
    start = 1'b0;
    chk("ign_ready_after", 32'(ready), 32'd1);
    @(negedge clk);
    chk("ign_not_queued", 32'(ready), 32'd1);
    chk("ign_y_held", 32'(y), 32'h0246);

    // asynchronous reset mid-shift discards the op
    @(negedge clk);
    start = 1'b1; a = 16'hFFFF; amt = 4'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y", 32'(y), 32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
    chk("arst_sticky", 32'(sticky), 32'd0);
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (16) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("arst_no_done", 32'(seen_done), 32'd0);
    run_op("post_rst", 16'hF00F, 4'd5, 1'b0);

    for (int i = 0; i < 6; i++)
      run_op($sformatf("rnd%0d", i), 16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));

    e1800 = model(16'h1800, 4'd12, 1'b0);
    run_op("1800_12", 16'h1800, 4'd12, 1'b0);
    chk("model_sanity_1800", 32'(e1800.y), 32'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
